// File: rtl/fft_peak_trigger.sv
// Watches one FFT bin per 64-beat frame and fires a trigger after CONFIRM_FRAMES
// consecutive frames whose |re|+|im| exceeds the threshold, with a post-trigger holdoff.
module fft_peak_trigger #(
  parameter int unsigned CONFIRM_FRAMES = 2,
  parameter int unsigned HOLDOFF_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [31:0] T_DATA,
  input  logic        T_VALID,
  input  logic        T_LAST,
  output logic        T_READY,
  input  logic [3:0]  Frequency,
  input  logic [1:0]  Offset,
  input  logic [3:0]  Threshold,
  output logic        Trigger,
  output logic        FFT_Data_Ready,
  output logic        Frame_Error,
  output logic [16:0] Peak_Mag
);

  localparam int unsigned BIN_W  = 6;
  localparam int unsigned MAG_W  = 17;
  localparam int unsigned HIT_W  = 4;
  localparam int unsigned HOLD_W = 20;
  localparam logic [BIN_W-1:0]  LAST_BIN  = '1;
  localparam logic [HIT_W-1:0]  CONFIRM   = HIT_W'(CONFIRM_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);

  typedef enum logic {COLLECT, EVAL} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [BIN_W-1:0]    tgt_q, tgt_d, tgt_eff;
  logic [3:0]          thr_q, thr_d;
  logic [MAG_W-1:0]    cap_q, cap_d;
  logic [HIT_W-1:0]    hits_q, hits_d, hits_inc;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [MAG_W-1:0]    peak_d;
  logic                ready_d, trig_d, fdr_d, err_d;
  logic [MAG_W-1:0]    re_ext, im_ext, abs_re, abs_im, mag, mag_fin;
  logic                beat, hit, fire;

  // Magnitude of the beat on the bus and the frame-end hit/fire decision
  always_comb begin
    re_ext   = {T_DATA[15], T_DATA[15:0]};
    im_ext   = {T_DATA[31], T_DATA[31:16]};
    abs_re   = T_DATA[15] ? MAG_W'(MAG_W'(0) - re_ext) : re_ext;
    abs_im   = T_DATA[31] ? MAG_W'(MAG_W'(0) - im_ext) : im_ext;
    mag      = abs_re + abs_im;
    beat     = T_VALID & T_READY;
    tgt_eff  = (bin_q == '0) ? {Frequency, Offset} : tgt_q;
    mag_fin  = (bin_q == tgt_eff) ? mag : cap_q;
    hit      = mag_fin > MAG_W'({thr_q, 12'b0});
    hits_inc = hit ? ((hits_q >= CONFIRM) ? CONFIRM : hits_q + HIT_W'(1)) : '0;
    // holdoff seen here is one cycle older than in EVAL, hence <= 1
    fire     = hit && (hits_inc == CONFIRM) && (hold_q <= HOLD_W'(1));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    tgt_d   = tgt_q;
    thr_d   = thr_q;
    cap_d   = cap_q;
    hits_d  = hits_q;
    hold_d  = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;
    peak_d  = Peak_Mag;
    trig_d  = 1'b0;
    fdr_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (beat) begin
          if (bin_q == '0) begin
            tgt_d = {Frequency, Offset};
            thr_d = Threshold;
          end
          if (bin_q == tgt_eff) cap_d = mag;
          if (T_LAST && (bin_q == LAST_BIN)) begin
            state_d = EVAL;
            bin_d   = '0;
            fdr_d   = 1'b1;
            peak_d  = mag_fin;
            trig_d  = fire;
            hits_d  = fire ? '0 : hits_inc;
          end else if (T_LAST || (bin_q == LAST_BIN)) begin
            err_d  = 1'b1;
            bin_d  = '0;
            hits_d = '0;
          end else begin
            bin_d = bin_q + BIN_W'(1);
          end
        end
      end
      EVAL: begin
        state_d = COLLECT;
        if (Trigger) hold_d = HOLD_LOAD;
      end
      default: state_d = COLLECT;
    endcase
    ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_q        <= COLLECT;
      bin_q          <= '0;
      tgt_q          <= '0;
      thr_q          <= '0;
      cap_q          <= '0;
      hits_q         <= '0;
      hold_q         <= '0;
      Peak_Mag       <= '0;
      T_READY        <= 1'b0;
      Trigger        <= 1'b0;
      FFT_Data_Ready <= 1'b0;
      Frame_Error    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bin_q          <= bin_d;
      tgt_q          <= tgt_d;
      thr_q          <= thr_d;
      cap_q          <= cap_d;
      hits_q         <= hits_d;
      hold_q         <= hold_d;
      Peak_Mag       <= peak_d;
      T_READY        <= ready_d;
      Trigger        <= trig_d;
      FFT_Data_Ready <= fdr_d;
      Frame_Error    <= err_d;
    end
  end

endmodule

// File: tb/tb_fft_peak_trigger.sv
// Directed bench for fft_peak_trigger: frames driven beat by beat, outputs checked
// by immediate assertions against hand-computed values.
module tb_fft_peak_trigger;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [31:0] T_DATA;
  logic        T_VALID, T_LAST, T_READY;
  logic [3:0]  Frequency;
  logic [1:0]  Offset;
  logic [3:0]  Threshold;
  logic        Trigger, FFT_Data_Ready, Frame_Error;
  logic [16:0] Peak_Mag;

  int n_checks = 0;
  int n_fail   = 0;

  logic o_trig, o_fdr, o_err, o_rdy;
  logic o2_trig, o2_fdr, o2_err, o2_rdy;
  logic [16:0] o2_peak;

  // bin 13 payloads as {imag, real}
  localparam logic [31:0] HOT_7000  = 32'hF830_1388;
  localparam logic [31:0] HOT_4096  = 32'h0000_1000;
  localparam logic [31:0] HOT_4097  = 32'hFF9F_0FA0;
  localparam logic [31:0] HOT_65536 = 32'h8000_8000;
  localparam logic [31:0] HOT_1     = 32'h0000_0001;
  localparam logic [31:0] HOT_100   = 32'h0000_0064;

  fft_peak_trigger #(.CONFIRM_FRAMES(2), .HOLDOFF_CYCLES(300)) dut (
    .clk(clk), .reset_b(reset_b), .T_DATA(T_DATA), .T_VALID(T_VALID), .T_LAST(T_LAST),
    .T_READY(T_READY), .Frequency(Frequency), .Offset(Offset), .Threshold(Threshold),
    .Trigger(Trigger), .FFT_Data_Ready(FFT_Data_Ready), .Frame_Error(Frame_Error),
    .Peak_Mag(Peak_Mag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_b = 1'b1;
    T_VALID = 1'b0;
    T_LAST  = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    int waits;
    @(negedge clk);
    T_DATA  = d;
    T_LAST  = last;
    T_VALID = 1'b1;
    waits = 0;
    while (!T_READY && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (waits == 10) chk("ready_timeout", 32'(T_READY), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int nbeats, input int last_idx, input logic [31:0] hot,
                            input bit scramble);
    logic [3:0] f_save;
    logic [1:0] o_save;
    logic [3:0] t_save;
    f_save = Frequency; o_save = Offset; t_save = Threshold;
    for (int i = 0; i < nbeats; i++) begin
      beat((i == 13) ? hot : 32'h0, i == last_idx);
      if (scramble && i == 0) begin
        Frequency = 4'd0; Offset = 2'd0; Threshold = 4'hF;
      end
    end
    @(negedge clk);
    o_trig = Trigger; o_fdr = FFT_Data_Ready; o_err = Frame_Error; o_rdy = T_READY;
    T_VALID = 1'b0; T_LAST = 1'b0;
    Frequency = f_save; Offset = o_save; Threshold = t_save;
    @(negedge clk);
    o2_trig = Trigger; o2_fdr = FFT_Data_Ready; o2_err = Frame_Error; o2_rdy = T_READY;
    o2_peak = Peak_Mag;
  endtask

  task automatic expect_frame(input string tag, input logic trig, input logic fdr,
                              input logic err, input logic [16:0] peak);
    chk({tag, "_trig"}, 32'(o_trig), 32'(trig));
    chk({tag, "_fdr"},  32'(o_fdr),  32'(fdr));
    chk({tag, "_err"},  32'(o_err),  32'(err));
    chk({tag, "_rdy"},  32'(o_rdy),  32'(!fdr));
    chk({tag, "_pulse"}, 32'({o2_trig, o2_fdr, o2_err}), 32'd0);
    chk({tag, "_rdy2"}, 32'(o2_rdy), 32'd1);
    chk({tag, "_peak"}, 32'(o2_peak), 32'(peak));
  endtask

  initial begin
    reset_b = 1'b1; T_DATA = '0; T_VALID = 1'b0; T_LAST = 1'b0;
    Frequency = 4'd3; Offset = 2'd1; Threshold = 4'd1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(T_READY), 32'd0);
    chk("rst_flags", 32'({Trigger, FFT_Data_Ready, Frame_Error}), 32'd0);
    chk("rst_peak", 32'(Peak_Mag), 32'd0);
    reset_b = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(T_READY), 32'd1);

    // Two 7000 frames: trigger on the second only
    send_frame(64, 63, HOT_7000, 1'b0); expect_frame("basic1", 1'b0, 1'b1, 1'b0, 17'd7000);
    send_frame(64, 63, HOT_7000, 1'b0); expect_frame("basic2", 1'b1, 1'b1, 1'b0, 17'd7000);

    // Threshold is strict: 4096 misses, 4097 hits
    do_reset();
    send_frame(64, 63, HOT_4096, 1'b0); expect_frame("eq1", 1'b0, 1'b1, 1'b0, 17'd4096);
    send_frame(64, 63, HOT_4096, 1'b0); expect_frame("eq2", 1'b0, 1'b1, 1'b0, 17'd4096);
    send_frame(64, 63, HOT_4097, 1'b0); expect_frame("gt1", 1'b0, 1'b1, 1'b0, 17'd4097);
    send_frame(64, 63, HOT_4097, 1'b0); expect_frame("gt2", 1'b1, 1'b1, 1'b0, 17'd4097);

    // Hit, miss, hit (full-scale negative bin), hit
    do_reset();
    send_frame(64, 63, HOT_7000,  1'b0); expect_frame("hm1", 1'b0, 1'b1, 1'b0, 17'd7000);
    send_frame(64, 63, 32'h0,     1'b0); expect_frame("hm2", 1'b0, 1'b1, 1'b0, 17'd0);
    send_frame(64, 63, HOT_65536, 1'b0); expect_frame("hm3", 1'b0, 1'b1, 1'b0, 17'd65536);
    send_frame(64, 63, HOT_7000,  1'b0); expect_frame("hm4", 1'b1, 1'b1, 1'b0, 17'd7000);

    // Threshold 0, and config changes mid-frame are ignored
    do_reset();
    Threshold = 4'd0;
    send_frame(64, 63, HOT_1, 1'b0); expect_frame("thr0_1", 1'b0, 1'b1, 1'b0, 17'd1);
    send_frame(64, 63, HOT_1, 1'b1); expect_frame("thr0_2", 1'b1, 1'b1, 1'b0, 17'd1);
    Threshold = 4'd1;

    // Holdoff 300 over 66-cycle frames: triggers on frames 2 and 7
    do_reset();
    begin
      logic [7:0] exp_trig;
      exp_trig = 8'b0100_0010;
      for (int f = 0; f < 8; f++) begin
        send_frame(64, 63, HOT_7000, 1'b0);
        expect_frame($sformatf("hold%0d", f + 1), exp_trig[f], 1'b1, 1'b0, 17'd7000);
      end
    end

    // Malformed frames
    do_reset();
    send_frame(64, 63, HOT_7000, 1'b0); expect_frame("err_pre", 1'b0, 1'b1, 1'b0, 17'd7000);
    send_frame(41, 40, HOT_100,  1'b0); expect_frame("err_early", 1'b0, 1'b0, 1'b1, 17'd7000);
    send_frame(64, 63, HOT_7000, 1'b0); expect_frame("err_after1", 1'b0, 1'b1, 1'b0, 17'd7000);
    send_frame(64, 63, HOT_7000, 1'b0); expect_frame("err_after2", 1'b1, 1'b1, 1'b0, 17'd7000);
    send_frame(64, -1, HOT_100,  1'b0); expect_frame("err_nolast", 1'b0, 1'b0, 1'b1, 17'd7000);
    send_frame(64, 63, HOT_4097, 1'b0); expect_frame("err_resume", 1'b0, 1'b1, 1'b0, 17'd4097);

    // Reset in the middle of a hit frame with hit count 1
    do_reset();
    send_frame(64, 63, HOT_7000, 1'b0); expect_frame("mrst_pre", 1'b0, 1'b1, 1'b0, 17'd7000);
    for (int i = 0; i < 30; i++) beat((i == 13) ? HOT_7000 : 32'h0, 1'b0);
    @(negedge clk);
    reset_b = 1'b1;
    T_DATA  = 32'h0;
    @(negedge clk);
    chk("mrst_ready", 32'(T_READY), 32'd0);
    chk("mrst_flags", 32'({Trigger, FFT_Data_Ready, Frame_Error}), 32'd0);
    chk("mrst_peak", 32'(Peak_Mag), 32'd0);
    reset_b = 1'b0;
    T_VALID = 1'b0;
    send_frame(64, 63, HOT_7000, 1'b0); expect_frame("mrst_1", 1'b0, 1'b1, 1'b0, 17'd7000);
    send_frame(64, 63, HOT_7000, 1'b0); expect_frame("mrst_2", 1'b1, 1'b1, 1'b0, 17'd7000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_peak_trigger.md
FFT_PEAK_TRIGGER -- requirements
Module: fft_peak_trigger

Interface
REQ-001 Parameter CONFIRM_FRAMES, default 2: consecutive above-threshold frames required to fire Trigger (legal range 1..15).
REQ-002 Parameter HOLDOFF_CYCLES, default 1000: clk cycles after a Trigger during which further triggers are suppressed (legal range 1..2^20-1).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_b  in  1  synchronous, active-high reset (asserted = 1).
REQ-005 T_DATA  in  32  FFT bin: [15:0] real, [31:16] imaginary, both signed two's complement.
REQ-006 T_VALID  in  1  FFT master valid.
REQ-007 T_LAST  in  1  last bin of frame.
REQ-008 T_READY  out  1  accept strobe to FFT; a beat transfers when T_VALID & T_READY.
REQ-009 Frequency  in  4  target bin MSBs.
REQ-010 Offset  in  2  target bin LSBs; target bin = {Frequency, Offset} (0..63).
REQ-011 Threshold  in  4  magnitude threshold; effective threshold = {Threshold, 12'b0}, 17 bits.
REQ-012 Trigger  out  1  one-cycle pulse on confirmed detection.
REQ-013 FFT_Data_Ready  out  1  one-cycle pulse per correctly framed, evaluated frame.
REQ-014 Frame_Error  out  1  one-cycle pulse per malformed frame.
REQ-015 Peak_Mag  out  17  target-bin magnitude of the last evaluated frame.

Function
REQ-016 Frame is exactly 64 beats, bin index 0..63 in order of acceptance; 6-bit bin counter increments per accepted beat.
REQ-017 Frequency, Offset, Threshold sampled on the accepted beat with bin counter = 0 and held for the frame.
REQ-018 Magnitude = |real| + |imag|, 17-bit unsigned; |-32768| = 32768; no saturation needed (max 65536).
REQ-019 Magnitude of the beat whose index equals the sampled target bin is captured into a frame register.
REQ-020 States: COLLECT, EVAL, HOLDOFF-tracked by independent counter (not a state).
REQ-021 COLLECT: T_READY = 1; accepting a beat with T_LAST = 1 -> EVAL next cycle, bin counter cleared.
REQ-022 Good frame: T_LAST accepted exactly at index 63. Bad frame: T_LAST at index != 63, or index 63 accepted with T_LAST = 0.
REQ-023 Bad frame: Frame_Error pulses the cycle after the offending beat, bin counter cleared, hit counter cleared, no EVAL, Peak_Mag unchanged; a bad frame ending without T_LAST resumes COLLECT at index 0 with the next beat.
REQ-024 EVAL lasts exactly 1 cycle, T_READY = 0; returns to COLLECT.
REQ-025 In EVAL: Peak_Mag <= captured magnitude; FFT_Data_Ready = 1; hit = captured magnitude > effective threshold (strict).
REQ-026 Hit counter (4-bit, saturating at CONFIRM_FRAMES): hit -> increment; miss -> clear.
REQ-027 Trigger = 1 in EVAL when post-update hit count = CONFIRM_FRAMES and holdoff counter = 0; on Trigger, hit counter cleared and holdoff counter loaded with HOLDOFF_CYCLES.
REQ-028 Holdoff counter (20-bit) decrements every clk while nonzero, independent of frame activity; hits during holdoff still count but cannot fire until counter = 0.
REQ-029 Latency: Trigger and FFT_Data_Ready assert 1 cycle after the T_LAST beat is accepted.
REQ-030 Threshold = 0: any nonzero magnitude is a hit.
REQ-031 Input changes on Frequency/Offset/Threshold mid-frame have no effect until the next frame's index-0 beat.

Reset
REQ-032 While reset_b = 1: state COLLECT, bin counter 0, hit counter 0, holdoff counter 0, captured magnitude 0, Peak_Mag 0, Trigger 0, FFT_Data_Ready 0, Frame_Error 0, T_READY 0.
REQ-033 First cycle after reset release: T_READY = 1; a partial frame in flight at reset is discarded without Frame_Error.

Verification
REQ-034 CONFIRM_FRAMES=2, Frequency=3, Offset=1, Threshold=1; two good frames with bin 13 = (real 5000, imag -2000), others 0 -> FFT_Data_Ready on both frames, Peak_Mag = 7000, Trigger on second frame only, 1 cycle after T_LAST.
REQ-035 Same setup, bin 13 magnitude 4096 exactly -> no hit, no Trigger; magnitude 4097 -> hit.
REQ-036 Hit, miss, hit, hit frames -> single Trigger on fourth frame; hit counter cleared by the miss.
REQ-037 HOLDOFF_CYCLES=300, continuous hit frames (66-cycle period incl. EVAL) -> Trigger on frame 2, next Trigger on first EVAL with holdoff counter = 0 (frame 7); T_READY low exactly one cycle per frame.
REQ-038 T_LAST at index 40 -> Frame_Error pulse, no FFT_Data_Ready, Peak_Mag unchanged, next frame evaluates normally; 64 beats without T_LAST -> Frame_Error after index 63.
REQ-039 Assert reset_b for 1 cycle at index 30 of a hit frame with hit count 1 -> all outputs 0, next full hit frame gives hit count 1 and no Trigger.
